// File: rtl/reg_file_nport.sv
// reg_file_nport: parametrised two-read / one-write register file with
// optional hardwired-zero entry 0, write-to-read bypass, optional registered
// read stage and a sequenced bulk-clear engine (busy / clr_done / wr_drop).
module reg_file_nport #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int READ_LAT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              we,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_done,
    output logic              wr_drop
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              clr_done_q;
    logic              wr_drop_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              busy_w;
    logic              last_w;
    logic              wr_legal_w;
    logic [DATA_W-1:0] rv1_w, rv2_w;

    assign busy_w     = (state_q == ST_CLEAR);
    // Exit is decided on the last index, not on the counter wrapping to 0.
    assign last_w     = (cnt_q == {ADDR_W{1'b1}});
    assign wr_legal_w = we && !busy_w && !((ZERO_REG != 0) && (wa == '0));

    // Read value for one port, highest-priority rule first.
    function automatic logic [DATA_W-1:0] read_val(input logic [ADDR_W-1:0] ra);
        if (busy_w)
            return '0;
        else if ((ZERO_REG != 0) && (ra == '0))
            return '0;
        else if ((BYPASS != 0) && wr_legal_w && (wa == ra))
            return wd;
        else
            return mem_q[ra];
    endfunction

    assign rv1_w = read_val(ra1);
    assign rv2_w = read_val(ra2);

    // Clear FSM next-state: IDLE waits for a request, CLEAR walks every index.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (last_w) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Clear FSM state and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Registered one-cycle event pulses: clear finished, write discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_done_q <= 1'b0;
            wr_drop_q  <= 1'b0;
        end else begin
            clr_done_q <= busy_w && last_w;
            wr_drop_q  <= we && busy_w;
        end
    end

    // Storage array: clear engine owns the write path while busy.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the array is reset on purpose; every entry must read 0 right
        // after reset, so it cannot map onto a reset-less RAM macro.
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[ADDR_W'(i)] <= '0;
        end else if (busy_w) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_legal_w) begin
            mem_q[wa] <= wd;
        end
    end

    generate
        if (READ_LAT != 0) begin : g_rd_reg
            logic [DATA_W-1:0] rd1_q, rd2_q;

            // Registered read stage: value sampled at the edge, held one cycle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd1_q <= '0;
                    rd2_q <= '0;
                end else begin
                    rd1_q <= rv1_w;
                    rd2_q <= rv2_w;
                end
            end

            assign rd1 = rd1_q;
            assign rd2 = rd2_q;
        end else begin : g_rd_comb
            assign rd1 = rv1_w;
            assign rd2 = rv2_w;
        end
    endgenerate

    assign busy     = busy_w;
    assign clr_done = clr_done_q;
    assign wr_drop  = wr_drop_q;

endmodule

// File: tb/tb_reg_file_nport.sv
// tb_reg_file_nport: drives two register-file configurations from one shared
// stimulus stream and compares both against a behavioural model.
//   dut_a: ZERO_REG=1, BYPASS=1, READ_LAT=0
//   dut_b: ZERO_REG=0, BYPASS=0, READ_LAT=1
module tb_reg_file_nport;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] ra1, ra2, wa;
    logic [DW-1:0] wd;
    logic          we, clr_req;

    logic [DW-1:0] rda1, rda2, rdb1, rdb2;
    logic          busy_a, done_a, drop_a;
    logic          busy_b, done_b, drop_b;

    always #5 clk = ~clk;

    reg_file_nport #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1), .READ_LAT(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(rda1), .rd2(rda2),
        .wa(wa), .wd(wd), .we(we), .clr_req(clr_req),
        .busy(busy_a), .clr_done(done_a), .wr_drop(drop_a)
    );

    reg_file_nport #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0), .BYPASS(0), .READ_LAT(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(rdb1), .rd2(rdb2),
        .wa(wa), .wd(wd), .we(we), .clr_req(clr_req),
        .busy(busy_b), .clr_done(done_b), .wr_drop(drop_b)
    );

    // Reference model: two plain arrays and a countdown of clear cycles left.
    logic [DW-1:0] mem_a [DEPTH];
    logic [DW-1:0] mem_b [DEPTH];
    int            clr_left;
    logic          exp_done, exp_drop;
    logic [DW-1:0] exp_b1, exp_b2;
    int            total, bad;
    int            busy_cnt, done_cnt;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_read(input bit cfg_b, input logic [AW-1:0] ra);
        bit zero_en = !cfg_b;
        bit byp_en  = !cfg_b;
        if (clr_left > 0) return '0;
        if (zero_en && ra == '0) return '0;
        if (byp_en && we && wa == ra && !(zero_en && wa == '0)) return wd;
        return cfg_b ? mem_b[ra] : mem_a[ra];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        clr_left = 0;
        exp_done = 1'b0;
        exp_drop = 1'b0;
        exp_b1   = '0;
        exp_b2   = '0;
    endtask

    task automatic model_edge();
        bit is_busy = (clr_left > 0);
        exp_drop = we && is_busy;
        exp_done = (clr_left == 1);
        if (is_busy) begin
            mem_a[DEPTH - clr_left] = '0;
            mem_b[DEPTH - clr_left] = '0;
            clr_left--;
        end else begin
            if (we) begin
                if (wa != '0) mem_a[wa] = wd;
                mem_b[wa] = wd;
            end
            if (clr_req) clr_left = DEPTH;
        end
    endtask

    // One clock: check combinational outputs mid-cycle, clock, check registered ones.
    task automatic cycle();
        logic [DW-1:0] nb1, nb2;
        #1;
        check("rd1_a", rda1, model_read(1'b0, ra1));
        check("rd2_a", rda2, model_read(1'b0, ra2));
        nb1 = model_read(1'b1, ra1);
        nb2 = model_read(1'b1, ra2);
        @(posedge clk);
        model_edge();
        exp_b1 = nb1;
        exp_b2 = nb2;
        #1;
        check("rd1_b", rdb1, exp_b1);
        check("rd2_b", rdb2, exp_b2);
        check("busy_a", DW'(busy_a), DW'(clr_left > 0));
        check("busy_b", DW'(busy_b), DW'(clr_left > 0));
        check("done_a", DW'(done_a), DW'(exp_done));
        check("done_b", DW'(done_b), DW'(exp_done));
        check("drop_a", DW'(drop_a), DW'(exp_drop));
        check("drop_b", DW'(drop_b), DW'(exp_drop));
    endtask

    initial begin
        total = 0; bad = 0;
        we = 1'b0; clr_req = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;
        rst_n = 1'b1;
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", DW'(busy_a), '0);
        check("rst_rdb1", rdb1, '0);
        check("rst_done", DW'(done_b), '0);
        check("rst_drop", DW'(drop_b), '0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Write 0xDEADBEEF to x5; rd1 is 0 before, the value after.
        ra1 = 5; ra2 = 0;
        cycle();
        we = 1'b1; wa = 5; wd = 32'hDEADBEEF;
        cycle();
        we = 1'b0;
        cycle();
        check("x5_a", rda1, 32'hDEADBEEF);
        check("x5_b", rdb1, 32'hDEADBEEF);

        // Same-cycle bypass on port 2 (dut_a) versus stored value (dut_b).
        we = 1'b1; wa = 7; wd = 32'h12345678; ra2 = 7;
        #1 check("bypass_a", rda2, 32'h12345678);
        cycle();
        check("nobypass_b", rdb2, '0);

        // Write all-ones to x0: ignored with ZERO_REG=1, stored otherwise.
        we = 1'b1; wa = 0; wd = 32'hFFFFFFFF; ra1 = 0;
        cycle();
        we = 1'b0;
        cycle();
        check("x0_a", rda1, '0);
        check("x0_b", rdb1, 32'hFFFFFFFF);
        check("x0_drop", DW'(drop_a), '0);

        // Registered read latency: x3=0x33, x4=0x44, switch ra1 from 3 to 4.
        we = 1'b1; wa = 3; wd = 32'h33; cycle();
        wa = 4; wd = 32'h44; cycle();
        we = 1'b0; ra1 = 3; cycle();
        ra1 = 4;
        #1 check("lat_hold", rdb1, 32'h33);
        cycle();
        check("lat_new", rdb1, 32'h44);

        // Fill x1..x31 with their index.
        for (int i = 1; i < DEPTH; i++) begin
            we = 1'b1; wa = AW'(i); wd = DW'(i);
            cycle();
        end

        // Clear request together with a legal write; then a dropped write and
        // a repeated request mid-sequence.
        we = 1'b1; wa = 9; wd = 32'hAAAA_5555; clr_req = 1'b1;
        cycle();
        we = 1'b0; clr_req = 1'b0;
        busy_cnt = int'(busy_a); done_cnt = int'(done_a);
        for (int k = 0; k < 40; k++) begin
            we      = (k == 5);
            wa      = 3;
            wd      = 32'h5555;
            clr_req = (k == 12);
            ra1     = AW'(k);
            cycle();
            busy_cnt += int'(busy_a);
            done_cnt += int'(done_a);
            if (k == 5) check("mid_drop", DW'(drop_a), 32'd1);
        end
        we = 1'b0; clr_req = 1'b0;
        check("busy_len", DW'(busy_cnt), 32'd32);
        check("done_cnt", DW'(done_cnt), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            ra1 = AW'(i); ra2 = AW'(DEPTH - 1 - i);
            cycle();
            check("cleared", rda1, '0);
        end

        // Randomised traffic with occasional clear requests.
        for (int n = 0; n < 400; n++) begin
            we      = 1'($urandom_range(0, 1));
            wa      = AW'($urandom);
            wd      = $urandom;
            ra1     = AW'($urandom);
            ra2     = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom);
            if ($urandom_range(0, 7) == 0) ra1 = ra2;
            clr_req = ($urandom_range(0, 59) == 0);
            cycle();
        end
        clr_req = 1'b0;

        // Fill with non-zero data, start a clear, reset asynchronously at cnt=10.
        for (int i = 0; i < DEPTH; i++) begin
            we = 1'b1; wa = AW'(i); wd = 32'hC000_0000 | DW'(i);
            cycle();
        end
        we = 1'b0; clr_req = 1'b1;
        cycle();
        clr_req = 1'b0;
        for (int k = 0; k < 10; k++) cycle();
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy_a", DW'(busy_a), '0);
        check("arst_busy_b", DW'(busy_b), '0);
        check("arst_rdb1", rdb1, '0);
        model_reset();
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        done_cnt = 0;
        for (int i = 0; i < DEPTH + 8; i++) begin
            ra1 = AW'(i % DEPTH); ra2 = AW'((i + 7) % DEPTH);
            cycle();
            done_cnt += int'(done_a) + int'(done_b);
            if (i < DEPTH) check("arst_zero", rda1, '0);
        end
        check("arst_nodone", DW'(done_cnt), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
